multicycle_rv_core: RTL
=======================

Name: multicycle_rv_core

Overview:
- Multi-cycle RV32I-subset core. Successor to the single-cycle datapath.
- Holds its own PC, instruction register, register file, ALU and control FSM.
- One shared memory port with a req/ack handshake, so instructions and data come from one external memory that may insert wait states.
- Register count and address width are parametrised; illegal and misaligned cases trap to a halt state.

Parameters:
- RESET_PC, 0, PC value loaded on reset.
- ADDR_W, 32, width of mem_addr; the low ADDR_W bits of each 32-bit address are driven.
- NREGS, 32, architectural registers (32 = RV32I, 16 = RV32E). Any rs1/rs2/rd index >= NREGS traps as illegal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  byte address, always word-aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the ack cycle.
- mem_ack  in  1  request completes in this cycle.
- pc  out  32  current PC.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  core is in HALT.
- trap_cause  out  2  00 none, 01 illegal instruction, 10 misaligned data address, 11 misaligned branch target.

Behaviour:
- Reset (rst high at an edge):
  - state = FETCH, pc = RESET_PC.
  - All registers cleared to 0; ir cleared.
  - retire = 0, halted = 0, trap_cause = 00.
  - mem_req is forced 0 while rst is high.
  - Reset mid-transaction abandons the request; a late mem_ack is ignored.
- Supported instructions:
  - R-type: add, sub, and, or, slt.
  - addi, lw, sw, beq.
  - Any other opcode/funct combination is illegal.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ack: ir <= mem_rdata, go to DECODE. Otherwise stay.
- DECODE:
  - A <= x[rs1], B <= x[rs2], imm <= sign-extended immediate (I, S or B format).
  - Illegal instruction or register index >= NREGS: trap_cause=01, go to HALT.
- EXEC:
  - alu_out <= A op (B or imm). Arithmetic is mod 2^32; slt is signed.
  - R-type/addi go to WB. lw/sw go to MEM.
  - lw/sw with alu_out[1:0] != 0: trap_cause=10, go to HALT.
  - beq taken: target = pc + imm. If target[1:0] != 0, trap_cause=11 and go to HALT; otherwise pc <= target, retire, go to FETCH.
  - beq not taken: pc <= pc+4, retire, go to FETCH.
- MEM:
  - Drives mem_req=1, mem_addr=alu_out, mem_we = (sw), mem_wdata = B.
  - On ack for lw: mdr <= mem_rdata, go to WB.
  - On ack for sw: pc <= pc+4, retire, go to FETCH.
- WB:
  - x[rd] <= alu_out or mdr; writes to x0 are discarded.
  - pc <= pc+4, retire, go to FETCH.
- HALT:
  - mem_req=0, halted=1, trap_cause held. Exits only via rst.
  - pc holds the address of the faulting instruction.
- Handshake rules:
  - While mem_req=1 and no ack, mem_addr, mem_we and mem_wdata stay stable.
  - mem_ack while mem_req=0 is ignored.
  - Ack may arrive in the same cycle as the request (zero wait).
- Latency with zero-wait memory:
  - beq: 3 cycles. R-type/addi: 4. sw: 4. lw: 5.
  - Each memory wait cycle adds 1.
- retire is asserted for exactly the one cycle in which pc updates for a completed instruction.
- Read-after-write: the register file is written in WB before the next DECODE, so no hazards exist.
- pc wraps mod 2^32.

Test Plan:
- Zero-wait memory; program 0x00500093 (addi x1,x0,5), 0x00700113 (addi x2,x0,7), 0x002081B3 (add x3,x1,x2) -> x3=12; retire pulses at cycles 4, 8, 12 after reset release.
- Append 0x00302423 (sw x3,8(x0)) then 0x00802203 (lw x4,8(x0)) -> write at addr 8 with data 12; x4=12; lw takes 5 cycles.
- Memory holds ack low 3 cycles during fetch -> mem_req/mem_addr stable for all 3 cycles; instruction latency +3.
- 0xFE000EE3 (beq x0,x0,-4) at pc=0x10 -> pc=0x0C after 3 cycles; mem_addr of the next fetch = 0x0C.
- Illegal 0xFFFFFFFF at pc=0 -> halted=1, trap_cause=01, pc=0, mem_req held 0; lw with address 0x9 -> trap_cause=10; NREGS=16 with rd=x20 -> trap_cause=01.
- rst asserted mid-MEM with ack withheld, then released -> pc=RESET_PC, registers 0, first request is a fetch at RESET_PC; addi x0,x0,9 leaves x0=0.

Source files
------------

// File: rtl/multicycle_rv_core.sv
// Multi-cycle RV32I-subset core: add/sub/and/or/slt, addi, lw, sw, beq.
// Instructions and data share one req/ack memory port that may insert wait
// states. Illegal encodings and misaligned addresses stop the core in HALT.
module multicycle_rv_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          NREGS    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       pc,
    output logic              retire,
    output logic              halted,
    output logic [1:0]        trap_cause
);

    localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_ILL
    } op_t;

    localparam logic [1:0] TRAP_ILLEGAL  = 2'b01;
    localparam logic [1:0] TRAP_MIS_DATA = 2'b10;
    localparam logic [1:0] TRAP_MIS_BR   = 2'b11;

    state_t      state, state_n;
    op_t         op;
    logic [31:0] regs [NREGS];
    logic [31:0] ir, a_q, b_q, imm_q, alu_q, mdr_q, pc_q, pc_n;
    logic [31:0] imm_dec, alu_res, alu_opnd, br_target, pc_plus4;
    logic [1:0]  trap_q, trap_n;
    logic        use_rs1, use_rs2, use_rd, idx_bad;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;

    assign rs1_idx = ir[19:15];
    assign rs2_idx = ir[24:20];
    assign rd_idx  = ir[11:7];

    // Instruction decode from the held instruction register.
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        op      = OP_ILL;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (ir[6:0])
            7'b0110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                if (ir[31:25] == 7'b0000000) begin
                    case (ir[14:12])
                        3'b000:  op = OP_ADD;
                        3'b111:  op = OP_AND;
                        3'b110:  op = OP_OR;
                        3'b010:  op = OP_SLT;
                        default: op = OP_ILL;
                    endcase
                end else if (ir[31:25] == 7'b0100000 && ir[14:12] == 3'b000) begin
                    op = OP_SUB;
                end
            end
            7'b0010011: begin use_rs1 = 1'b1; use_rd  = 1'b1; if (ir[14:12] == 3'b000) op = OP_ADDI; end
            7'b0000011: begin use_rs1 = 1'b1; use_rd  = 1'b1; if (ir[14:12] == 3'b010) op = OP_LW;   end
            7'b0100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; if (ir[14:12] == 3'b010) op = OP_SW;   end
            7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; if (ir[14:12] == 3'b000) op = OP_BEQ;  end
            default:    op = OP_ILL;
        endcase
        idx_bad = (use_rs1 && int'(rs1_idx) >= NREGS) ||
                  (use_rs2 && int'(rs2_idx) >= NREGS) ||
                  (use_rd  && int'(rd_idx)  >= NREGS);
    end

    // Immediate extraction (S for stores, B for branches, I otherwise) and ALU.
    always_comb begin
        case (op)
            OP_SW:   imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BEQ:  imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default: imm_dec = {{20{ir[31]}}, ir[31:20]};
        endcase
        alu_opnd = (op == OP_ADDI || op == OP_LW || op == OP_SW) ? imm_q : b_q;
        case (op)
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
            default: alu_res = a_q + alu_opnd;
        endcase
        br_target = pc_q + imm_q;
        pc_plus4  = pc_q + 32'd4;
    end

    // Control FSM: next state, pc/trap updates and memory-port drive.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        trap_n  = trap_q;
        retire  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) state_n = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_ILL || idx_bad) begin
                    trap_n  = TRAP_ILLEGAL;
                    state_n = S_HALT;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op == OP_LW || op == OP_SW) begin
                    if (alu_res[1:0] != 2'b00) begin
                        trap_n  = TRAP_MIS_DATA;
                        state_n = S_HALT;
                    end else begin
                        state_n = S_MEM;
                    end
                end else if (op == OP_BEQ) begin
                    if (a_q == b_q && br_target[1:0] != 2'b00) begin
                        trap_n  = TRAP_MIS_BR;
                        state_n = S_HALT;
                    end else begin
                        pc_n    = (a_q == b_q) ? br_target : pc_plus4;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op == OP_SW);
                if (mem_ack) begin
                    if (op == OP_SW) begin
                        pc_n    = pc_plus4;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_n    = pc_plus4;
                retire  = 1'b1;
                state_n = S_FETCH;
            end
            default: state_n = S_HALT;
        endcase
        // An abandoned request must not stay visible while reset is held.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_n;
    end

    // Datapath registers and register file.
    // NOTE: the register file is cleared on reset because the core must start with all registers zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            trap_q <= 2'b00;
            ir     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            imm_q  <= '0;
            alu_q  <= '0;
            mdr_q  <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            pc_q   <= pc_n;
            trap_q <= trap_n;
            if (state == S_FETCH && mem_ack) ir <= mem_rdata;
            if (state == S_DECODE) begin
                a_q   <= regs[rs1_idx[RIDX_W-1:0]];
                b_q   <= regs[rs2_idx[RIDX_W-1:0]];
                imm_q <= imm_dec;
            end
            if (state == S_EXEC) alu_q <= alu_res;
            if (state == S_MEM && mem_ack && op == OP_LW) mdr_q <= mem_rdata;
            if (state == S_WB && rd_idx != 5'd0)
                regs[rd_idx[RIDX_W-1:0]] <= (op == OP_LW) ? mdr_q : alu_q;
        end
    end

    assign mem_addr   = (state == S_MEM) ? alu_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
    assign mem_wdata  = b_q;
    assign pc         = pc_q;
    assign halted     = (state == S_HALT);
    assign trap_cause = trap_q;

endmodule
